// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin arbiter sharing one external ALU across NUM_REQ requesters
// Optional macro ALU_ARB_PRIO_EN gives requester 0 fixed priority over the round-robin.
module alu_share_arb #(
  parameter int NUM_REQ = 2,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_op1,
  input  logic [NUM_REQ*32-1:0] req_op2,
  input  logic [NUM_REQ*4-1:0]  req_ctrl,
  output logic [31:0]           alu_op1,
  output logic [31:0]           alu_op2,
  output logic [3:0]            alu_control,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] id;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] next_ptr;
  logic            any_valid;

  // Descending scan so the lowest offset from start overwrites earlier hits.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    start,
                                              input logic               skip0);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (valid[idx] && !(skip0 && idx == 0)) pick = idx[ID_W-1:0];
    end
    return pick;
  endfunction

  always_comb begin
`ifdef ALU_ARB_PRIO_EN
    winner = req_valid[0] ? '0 : rr_pick(req_valid, rr_ptr, 1'b1);
`else
    winner = rr_pick(req_valid, rr_ptr, 1'b0);
`endif
    next_ptr  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    any_valid = |req_valid;
    req_ready = '0;
    if (state == IDLE && any_valid) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      id          <= '0;
      alu_op1     <= '0;
      alu_op2     <= '0;
      alu_control <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_id      <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            alu_op1     <= req_op1[winner*32 +: 32];
            alu_op2     <= req_op2[winner*32 +: 32];
            alu_control <= req_ctrl[winner*4 +: 4];
            id          <= winner;
`ifdef ALU_ARB_PRIO_EN
            if (winner != '0) rr_ptr <= next_ptr;
`else
            rr_ptr <= next_ptr;
`endif
            state <= EXEC;
          end
        end
        EXEC: begin
          // Unsupported codes still reach the ALU, but its output is not trusted.
          if (alu_control >= 4'b1110) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b1;
            rsp_err    <= 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_err    <= 1'b0;
          end
          rsp_id    <= id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed self-checking bench for alu_share_arb with a behavioural ALU
module tb_alu_share_arb;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_op1;
  logic [NUM_REQ*32-1:0] req_op2;
  logic [NUM_REQ*4-1:0]  req_ctrl;
  logic [31:0]           alu_op1;
  logic [31:0]           alu_op2;
  logic [3:0]            alu_control;
  logic [31:0]           alu_result;
  logic                  alu_zero;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_result;
  logic                  rsp_zero;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_err;

  int checks = 0;
  int errors = 0;

  alu_share_arb #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // External ALU; junk output on unsupported codes so the arbiter must override it.
  always_comb begin
    alu_result = 32'h0;
    alu_zero   = 1'b0;
    case (alu_control)
      4'b0000: alu_result = alu_op1 + alu_op2;
      4'b0001: alu_result = alu_op1 - alu_op2;
      4'b0010: alu_result = alu_op1 & alu_op2;
      4'b0011: alu_result = alu_op1 | alu_op2;
      4'b1110, 4'b1111: alu_result = 32'hFFFF_FFFF;
      default: alu_result = alu_op1 ^ alu_op2;
    endcase
    if (alu_control < 4'b1110) alu_zero = (alu_result == 32'h0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NUM_REQ-1:0] exp_gnt [4];
  logic [31:0]        exp_res [4];

  initial begin
`ifdef ALU_ARB_PRIO_EN
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_res = '{32'd3, 32'd3, 32'd3, 32'd3};
`else
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_res = '{32'd3, 32'd6, 32'd3, 32'd6};
`endif
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_op1 = '0; req_op2 = '0; req_ctrl = '0;
    tick(); tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_op1", alu_op1, 32'd0);
    check("rst_alu_ctrl", 32'(alu_control), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // Basic add from requester 0
    rst_n = 1'b1; req_valid = 2'b01;
    req_op1[31:0] = 32'd5; req_op2[31:0] = 32'd7; req_ctrl[3:0] = 4'b0000;
    #1 check("add_req_ready", 32'(req_ready), 32'b01);
    tick();
    req_valid = '0;
    check("add_alu_op1", alu_op1, 32'd5);
    check("add_alu_op2", alu_op2, 32'd7);
    check("add_exec_ready", 32'(req_ready), 32'd0);
    check("add_exec_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("add_rsp_valid", 32'(rsp_valid), 32'd1);
    check("add_rsp_result", rsp_result, 32'd12);
    check("add_rsp_zero", 32'(rsp_zero), 32'd0);
    check("add_rsp_id", 32'(rsp_id), 32'd0);
    check("add_rsp_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b1;
    tick();
    check("add_accept_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;

    // Requester 1 subtract to zero, then backpressure for 5 cycles
    req_valid = 2'b10;
    req_op1[63:32] = 32'd9; req_op2[63:32] = 32'd9; req_ctrl[7:4] = 4'b0001;
    #1 check("sub_req_ready", 32'(req_ready), 32'b10);
    tick();
    req_valid = 2'b11;
    req_op1[31:0] = 32'd1; req_op2[31:0] = 32'd2; req_ctrl[3:0] = 4'b0000;
    req_op1[63:32] = 32'd10; req_op2[63:32] = 32'd4;
    tick();
    check("sub_rsp_result", rsp_result, 32'd0);
    check("sub_rsp_zero", 32'(rsp_zero), 32'd1);
    check("sub_rsp_id", 32'(rsp_id), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_result", rsp_result, 32'd0);
      check("hold_id", 32'(rsp_id), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1 check("accept_cycle_ready", 32'(req_ready), 32'd0);
    tick();
    check("accept_valid", 32'(rsp_valid), 32'd0);

    // Both requesters valid continuously: grant order follows rr_ptr
    for (int i = 0; i < 4; i++) begin
      check("seq_grant", 32'(req_ready), 32'(exp_gnt[i]));
      tick();
      tick();
      check("seq_rsp_valid", 32'(rsp_valid), 32'd1);
      check("seq_rsp_id", 32'(rsp_id), (exp_gnt[i] == 2'b10) ? 32'd1 : 32'd0);
      check("seq_rsp_result", rsp_result, exp_res[i]);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();

    // Unsupported control code
    req_valid = 2'b01;
    req_op1[31:0] = 32'd3; req_op2[31:0] = 32'd4; req_ctrl[3:0] = 4'b1110;
    #1 check("bad_req_ready", 32'(req_ready), 32'b01);
    tick();
    req_valid = '0;
    check("bad_alu_ctrl", 32'(alu_control), 32'b1110);
    tick();
    check("bad_rsp_result", rsp_result, 32'd0);
    check("bad_rsp_zero", 32'(rsp_zero), 32'd1);
    check("bad_rsp_err", 32'(rsp_err), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset during EXEC drops the operation and resets rr_ptr
    req_valid = 2'b11;
    req_ctrl[3:0] = 4'b0000; req_op1[31:0] = 32'd20; req_op2[31:0] = 32'd22;
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_alu_op1", alu_op1, 32'd0);
    check("mid_rst_alu_op2", alu_op2, 32'd0);
    check("mid_rst_alu_ctrl", 32'(alu_control), 32'd0);
    check("mid_rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    #1 check("post_rst_grant", 32'(req_ready), 32'b01);
    tick();
    req_valid = '0;
    check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    tick();
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    check("post_rst_rsp_id", 32'(rsp_id), 32'd0);
    check("post_rst_result", rsp_result, 32'd42);
    rsp_ready = 1'b1;
    tick();
    check("post_rst_accept", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
